// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, sequences exception flushes, stall watchdog and counter
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);
  localparam logic [1:0] RUN = 2'd0, CATCH = 2'd1, FLUSH = 2'd2;
  localparam logic [3:0] FC_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] WD_LAST = 32'(WDOG_LIMIT - 1);
  logic [1:0] state, state_nxt;
  logic [3:0] fcnt;
  logic [31:0] wdog;
  logic [5:0] run_stall;
  always_comb begin
    run_stall = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
                stallreq_id ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    stall = state == CATCH ? 6'b111111 : state == FLUSH ? 6'b000000 : run_stall;
    state_nxt = state == RUN ? ((exc_valid && !stallreq_mem) ? CATCH : RUN) :
                state == CATCH ? FLUSH :
                (state == FLUSH && fcnt != 4'd0) ? FLUSH : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      flush <= 1'b0;
      new_pc <= 32'd0;
      fcnt <= 4'd0;
      wdog <= 32'd0;
      stall_timeout <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state <= state_nxt;
      flush <= state_nxt == FLUSH;
      if (state == CATCH) begin
        new_pc <= exc_target;
        fcnt <= FC_LAST;
      end else if (state == FLUSH && fcnt != 4'd0) fcnt <= fcnt - 4'd1;
      if (stall[0]) begin
        stall_cycles <= &stall_cycles ? stall_cycles : stall_cycles + 32'd1;
        wdog <= &wdog ? wdog : wdog + 32'd1;
        if (wdog >= WD_LAST) stall_timeout <= 1'b1;
      end else wdog <= 32'd0;
    end
  end
endmodule
